teclado_clave: RTL and testbench

TECLADO_CLAVE -- requirements
Module: teclado_clave

---
 rtl/teclado_clave.sv | 138 +++++++++++++
 tb/tb_teclado_clave.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/teclado_clave.sv
// Keypad PIN capture: collects four BCD digits, presents the PIN on enter and
// holds it until the access controller acknowledges it.
module teclado_clave #(
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        habilitado,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  input  logic        clave_ack,
  output logic [15:0] clave_ingresada,
  output logic        clave_valida,
  output logic [2:0]  digitos,
  output logic        error_formato,
  output logic        tecla_rechazada,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, CAPTURA, ENVIANDO} estado_t;

  localparam logic [15:0] CNT_FIN = 16'(TIMEOUT_CICLOS - 1);

  estado_t     state_reg, state_next;
  logic [15:0] buffer_reg, buffer_next;
  logic [2:0]  digitos_reg, digitos_next;
  logic [15:0] clave_reg, clave_next;
  logic        valida_reg, valida_next;
  logic        error_reg, error_next;
  logic        rech_reg, rech_next;
  logic        timeout_reg, timeout_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      buffer_reg  <= 16'h0000;
      digitos_reg <= 3'd0;
      clave_reg   <= 16'h0000;
      valida_reg  <= 1'b0;
      error_reg   <= 1'b0;
      rech_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      cnt_reg     <= 16'd0;
    end else begin
      state_reg   <= state_next;
      buffer_reg  <= buffer_next;
      digitos_reg <= digitos_next;
      clave_reg   <= clave_next;
      valida_reg  <= valida_next;
      error_reg   <= error_next;
      rech_reg    <= rech_next;
      timeout_reg <= timeout_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign cnt_inc = cnt_reg + 16'd1;

  always_comb begin
    state_next   = state_reg;
    buffer_next  = buffer_reg;
    digitos_next = digitos_reg;
    clave_next   = clave_reg;
    valida_next  = valida_reg;
    error_next   = 1'b0;
    rech_next    = 1'b0;
    timeout_next = 1'b0;
    cnt_next     = cnt_reg;

    if (!habilitado) begin
      state_next   = IDLE;
      buffer_next  = 16'h0000;
      digitos_next = 3'd0;
      valida_next  = 1'b0;
      cnt_next     = 16'd0;
      rech_next    = tecla_valida;
    end else if (state_reg == ENVIANDO) begin
      // PIN is frozen until acknowledged; every key is refused meanwhile
      cnt_next  = 16'd0;
      rech_next = tecla_valida;
      if (clave_ack) begin
        state_next  = IDLE;
        valida_next = 1'b0;
      end
    end else if (tecla_valida) begin
      // any strobed key, accepted or not, restarts the idle counter
      cnt_next = 16'd0;
      if (tecla == 4'hA) begin
        state_next   = IDLE;
        buffer_next  = 16'h0000;
        digitos_next = 3'd0;
      end else if (tecla == 4'hB) begin
        buffer_next  = 16'h0000;
        digitos_next = 3'd0;
        if (digitos_reg == 3'd4) begin
          clave_next  = buffer_reg;
          valida_next = 1'b1;
          state_next  = ENVIANDO;
        end else begin
          error_next = 1'b1;
          state_next = IDLE;
        end
      end else if (tecla <= 4'h9) begin
        if (digitos_reg < 3'd4) begin
          buffer_next  = {buffer_reg[11:0], tecla};
          digitos_next = digitos_reg + 3'd1;
          state_next   = CAPTURA;
        end else begin
          rech_next = 1'b1;
        end
      end else begin
        rech_next = 1'b1;
      end
    end else if (state_reg == CAPTURA) begin
      if (cnt_inc == CNT_FIN) begin
        timeout_next = 1'b1;
        state_next   = IDLE;
        buffer_next  = 16'h0000;
        digitos_next = 3'd0;
        cnt_next     = 16'd0;
      end else begin
        cnt_next = cnt_inc;
      end
    end else begin
      cnt_next = 16'd0;
    end
  end

  assign clave_ingresada = clave_reg;
  assign clave_valida    = valida_reg;
  assign digitos         = digitos_reg;
  assign error_formato   = error_reg;
  assign tecla_rechazada = rech_reg;
  assign timeout         = timeout_reg;

endmodule

// File: tb/tb_teclado_clave.sv
// Directed bench for teclado_clave: inputs change and outputs are sampled on
// the falling edge, so each key's effect is checked one falling edge later.
module tb_teclado_clave;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        habilitado = 1'b1;
  logic        tecla_valida = 1'b0;
  logic [3:0]  tecla = 4'h0;
  logic        clave_ack = 1'b0;
  logic [15:0] clave_ingresada;
  logic        clave_valida;
  logic [2:0]  digitos;
  logic        error_formato;
  logic        tecla_rechazada;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  teclado_clave #(.TIMEOUT_CICLOS(T)) dut (
    .clk(clk),
    .reset(reset),
    .habilitado(habilitado),
    .tecla_valida(tecla_valida),
    .tecla(tecla),
    .clave_ack(clave_ack),
    .clave_ingresada(clave_ingresada),
    .clave_valida(clave_valida),
    .digitos(digitos),
    .error_formato(error_formato),
    .tecla_rechazada(tecla_rechazada),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the key applied.
  task automatic press(input logic [3:0] k);
    tecla_valida = 1'b1;
    tecla = k;
    @(negedge clk);
    tecla_valida = 1'b0;
    tecla = 4'h0;
  endtask

  task automatic ack();
    clave_ack = 1'b1;
    @(negedge clk);
    clave_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".clave"}, 32'(clave_ingresada), 32'h0);
    check({tag, ".valida"}, 32'(clave_valida), 32'h0);
    check({tag, ".digitos"}, 32'(digitos), 32'h0);
    check({tag, ".pulses"}, 32'({error_formato, tecla_rechazada, timeout}), 32'h0);
  endtask

  initial begin
    logic [3:0] pin_a [4] = '{4'h2, 4'h4, 4'h6, 4'h8};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // 2,4,6,8,B -> 2468 held until ack
    for (int i = 0; i < 4; i++) begin
      press(pin_a[i]);
      check("digitos_2468", 32'(digitos), 32'(i + 1));
    end
    press(4'hB);
    check("clave_2468", 32'(clave_ingresada), 32'h2468);
    check("valida_2468", 32'(clave_valida), 32'h1);
    check("digitos_after_enter", 32'(digitos), 32'h0);
    repeat (3) @(negedge clk);
    check("valida_held", 32'(clave_valida), 32'h1);
    press(4'h9);
    check("rech_enviando", 32'(tecla_rechazada), 32'h1);
    check("clave_stable", 32'(clave_ingresada), 32'h2468);
    @(negedge clk);
    check("rech_one_cycle", 32'(tecla_rechazada), 32'h0);
    ack();
    check("valida_after_ack", 32'(clave_valida), 32'h0);
    check("clave_retained", 32'(clave_ingresada), 32'h2468);

    // 1,2,B -> format error
    press(4'h1);
    press(4'h2);
    press(4'hB);
    check("error_formato", 32'(error_formato), 32'h1);
    check("err_digitos", 32'(digitos), 32'h0);
    check("err_valida", 32'(clave_valida), 32'h0);
    check("err_clave", 32'(clave_ingresada), 32'h2468);
    @(negedge clk);
    check("error_one_cycle", 32'(error_formato), 32'h0);

    // 1,2,3,4,5 -> fifth rejected, B -> 1234
    for (int i = 1; i <= 4; i++) press(4'(i));
    press(4'h5);
    check("rech_fifth", 32'(tecla_rechazada), 32'h1);
    check("digitos_full", 32'(digitos), 32'h4);
    press(4'hB);
    check("clave_1234", 32'(clave_ingresada), 32'h1234);
    check("valida_1234", 32'(clave_valida), 32'h1);
    ack();

    // habilitado dropped while presenting
    for (int i = 0; i < 4; i++) press(4'h1);
    press(4'hB);
    check("clave_1111", 32'(clave_ingresada), 32'h1111);
    habilitado = 1'b0;
    @(negedge clk);
    check("valida_hab0", 32'(clave_valida), 32'h0);
    habilitado = 1'b1;
    @(negedge clk);

    // timeout after T-1 idle cycles
    press(4'h7);
    repeat (T - 2) @(negedge clk);
    check("no_timeout_yet", 32'(timeout), 32'h0);
    check("digitos_before_to", 32'(digitos), 32'h1);
    @(negedge clk);
    check("timeout_pulse", 32'(timeout), 32'h1);
    check("timeout_digitos", 32'(digitos), 32'h0);
    @(negedge clk);
    check("timeout_one_cycle", 32'(timeout), 32'h0);

    // key exactly at expiry wins
    press(4'h7);
    repeat (T - 2) @(negedge clk);
    press(4'h3);
    check("expiry_key_no_to", 32'(timeout), 32'h0);
    check("expiry_key_digitos", 32'(digitos), 32'h2);

    // illegal key, then clear
    press(4'hE);
    check("rech_illegal", 32'(tecla_rechazada), 32'h1);
    check("illegal_digitos", 32'(digitos), 32'h2);
    press(4'hA);
    check("clear_digitos", 32'(digitos), 32'h0);
    check("clear_no_error", 32'(error_formato), 32'h0);

    // asynchronous reset mid-entry after loading a PIN
    for (int i = 0; i < 4; i++) press(4'h9);
    press(4'hB);
    ack();
    press(4'h3);
    press(4'h3);
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    press(4'h5);
    press(4'h6);
    press(4'h7);
    press(4'h8);
    press(4'hB);
    check("clave_5678", 32'(clave_ingresada), 32'h5678);
    check("valida_5678", 32'(clave_valida), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
